fifo_push_arbiter: RTL and testbench

- Shares the single push port of the team's general-purpose FIFO between NUM_REQ producers.
- Round-robin arbitration, one push at a time. The winner's data is latched at grant.
- The block drives the FIFO push/data_in and waits for the FIFO's registered ack, then returns a one-cycle ack to the winning producer.
- Sits directly in front of the FIFO, e.g. multiple UART/GPIO event sources feeding one buffer.

---
 rtl/fifo_push_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_push_arbiter
//
// Shares the single push port of a FIFO between NUM_REQ producers. Requests
// are served round-robin, one push at a time. The winner's payload is latched
// at grant, pushed into the FIFO, and once the FIFO returns its registered
// ack the winner gets a one-cycle req_ack. If the ack never arrives within
// ACK_TIMEOUT cycles, the transfer is dropped without req_ack, the sticky err
// flag is set, and the requester is simply re-arbitrated later.
//
// Transfer sequence: IDLE -> PUSH -> ACK_WAIT -> RELEASE -> IDLE. This takes
// at least 4 cycles, so the FIFO sees at most one push every 4 cycles.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   req_valid  in   [NUM_REQ]            per-requester request, held until req_ack
//   req_data   in   [NUM_REQ*DATA_WIDTH] packed payloads, requester i at
//                                        [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack    out  [NUM_REQ]            one-cycle pulse to the served requester
//   fifo_push  out                       FIFO push strobe
//   fifo_data  out  [DATA_WIDTH]         FIFO data_in
//   fifo_ack   in                        FIFO ack, high one cycle after a push
//   fifo_full  in                        FIFO full
//   busy       out                       high whenever a transfer is in flight
//   grant_id   out  [ID_WIDTH]           current / last granted requester
//   err        out                       sticky ack-timeout flag
//   err_clr    in                        synchronous clear for err
// ---------------------------------------------------------------------------
module fifo_push_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_WIDTH  = 8,
  parameter  int ACK_TIMEOUT = 7,
  localparam int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_ack,
  input  logic                          fifo_full,
  output logic                          busy,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          err,
  input  logic                          err_clr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUSH     = 2'd1,
    ACK_WAIT = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // NUM_REQ always fits in ID_WIDTH+1 bits, so the wrap arithmetic below is
  // done at that width.
  localparam logic [ID_WIDTH:0]   NUM_REQ_W    = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID      = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [7:0]          TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]     grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [7:0]              timer_q, timer_d;
  logic                    err_q, err_d;

  // Arbitration results
  logic [2*NUM_REQ-1:0]    req_dbl;
  logic [NUM_REQ-1:0]      req_rot;
  logic                    found;
  logic [ID_WIDTH-1:0]     offset;
  logic [ID_WIDTH:0]       sum;
  logic [ID_WIDTH-1:0]     winner;
  logic [DATA_WIDTH-1:0]   winner_data;

  // -------------------------------------------------------------------------
  // Round-robin search. The request vector is rotated so that rr_ptr lands on
  // bit 0; the lowest set bit of the rotated vector is the distance from
  // rr_ptr to the winner. Adding it back with an explicit wrap keeps the
  // result correct for non-power-of-two NUM_REQ.
  // -------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default on entry, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    req_dbl = {req_valid, req_valid} >> rr_ptr_q;
    req_rot = req_dbl[NUM_REQ-1:0];
    found   = 1'b0;
    offset  = '0;
    // Descending scan, last hit wins: the lowest set bit is selected.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found  = 1'b1;
        offset = ID_WIDTH'(k);
      end
    end
    sum = {1'b0, rr_ptr_q} + {1'b0, offset};
    if (sum >= NUM_REQ_W) begin
      winner = ID_WIDTH'(sum - NUM_REQ_W);
    end else begin
      winner = ID_WIDTH'(sum);
    end
  end

  // Payload of the winning requester
  always_comb begin
    winner_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == ID_WIDTH'(k)) begin
        winner_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    data_d     = data_q;
    timer_d    = timer_q;
    err_d      = err_q;

    // Clear first so that a timeout in the same cycle overrides it.
    if (err_clr) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // Never grant into a full FIFO; the requester keeps waiting.
        if (found && !fifo_full) begin
          grant_id_d = winner;
          data_d     = winner_data;
          state_d    = PUSH;
        end
      end

      PUSH: begin
        // The push only completes on a cycle where the FIFO can take it.
        if (!fifo_full) begin
          timer_d = '0;
          state_d = ACK_WAIT;
        end
      end

      ACK_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (fifo_ack) begin
          state_d = RELEASE;
        end else if (timer_q == TIMEOUT_LAST) begin
          // Abandon the transfer; rr_ptr is untouched so the same requester
          // retries on its own.
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      RELEASE: begin
        rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      data_q     <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      data_q     <= data_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so nothing on the requester
  // side reaches an output combinationally. fifo_full gating on fifo_push is
  // intentional: the push strobe must never assert into a full FIFO.
  // -------------------------------------------------------------------------
  always_comb begin
    req_ack = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ack[k] = (state_q == RELEASE) && (grant_id_q == ID_WIDTH'(k));
    end
  end

  assign fifo_push = (state_q == PUSH) && !fifo_full;
  assign fifo_data = data_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_id_q;
  assign err       = err_q;

  // -------------------------------------------------------------------------
  // Protocol properties
  // -------------------------------------------------------------------------
  a_ack_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ack));

  a_ack_single_cycle : assert property (@(posedge clk) disable iff (reset)
    (req_ack != '0) |=> (req_ack == '0));

  a_no_push_when_full : assert property (@(posedge clk) disable iff (reset)
    fifo_full |-> !fifo_push);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_push_arbiter
//
// Bench for fifo_push_arbiter (NUM_REQ=4, DATA_WIDTH=8, ACK_TIMEOUT=7) with a
// small FIFO model behind it. Directed stimulus queues the expected FIFO
// pushes (data, grant_id) and req_ack masks; an independent monitor pops and
// compares them whenever the DUT pushes or acks.
// ---------------------------------------------------------------------------
module tb_fifo_push_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
  } push_t;

  logic                   clk;
  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic [NUM_REQ-1:0]     req_ack;
  logic                   fifo_push;
  logic [DW-1:0]          fifo_data;
  logic                   fifo_ack;
  logic                   fifo_full;
  logic                   busy;
  logic [1:0]             grant_id;
  logic                   err;
  logic                   err_clr;

  // FIFO model
  logic [7:0]             mem [16];
  logic [3:0]             wr_ptr, rd_ptr;
  int                     cnt;
  int                     fifo_depth;
  logic                   pop_req;
  logic                   ack_en;
  logic                   ack_q;
  logic                   push_acc, pop_acc;
  logic [7:0]             data_out;

  // Scoreboard
  push_t                  exp_push [$];
  logic [3:0]             exp_ack  [$];
  int                     push_cyc [$];
  int                     cyc;
  int                     last_push_cyc;
  logic [3:0]             prev_ack;
  push_t                  mon_e;
  logic [3:0]             mon_a;
  int                     tests;
  int                     fails;

  fifo_push_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_WIDTH  (DW),
    .ACK_TIMEOUT (7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .fifo_push (fifo_push),
    .fifo_data (fifo_data),
    .fifo_ack  (fifo_ack),
    .fifo_full (fifo_full),
    .busy      (busy),
    .grant_id  (grant_id),
    .err       (err),
    .err_clr   (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO: registered ack one cycle after an accepted push (when enabled)
  assign fifo_full = (cnt >= fifo_depth);
  assign push_acc  = fifo_push && !fifo_full;
  assign pop_acc   = pop_req && (cnt != 0);
  assign fifo_ack  = ack_q;
  assign data_out  = mem[rd_ptr];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= 0;
      ack_q  <= 1'b0;
    end else begin
      if (push_acc) begin
        mem[wr_ptr] <= fifo_data;
        wr_ptr      <= wr_ptr + 4'd1;
      end
      if (pop_acc) rd_ptr <= rd_ptr + 4'd1;
      cnt   <= cnt + (push_acc ? 1 : 0) - (pop_acc ? 1 : 0);
      ack_q <= push_acc && ack_en;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every push and every ack against the queued expectations
  always @(negedge clk) begin
    if (reset) begin
      prev_ack = '0;
    end else begin
      if (fifo_push) begin
        check("push_while_full", fifo_full, 0);
        check("push_expected", exp_push.size() != 0, 1);
        if (exp_push.size() != 0) begin
          mon_e = exp_push.pop_front();
          check("push_data", fifo_data, mon_e.data);
          check("push_grant_id", grant_id, mon_e.id);
        end
        last_push_cyc = cyc;
        push_cyc.push_back(cyc);
      end
      if (req_ack != '0) begin
        check("ack_not_repeated", prev_ack, 0);
        check("ack_onehot", $onehot(req_ack), 1);
        check("ack_expected", exp_ack.size() != 0, 1);
        if (exp_ack.size() != 0) begin
          mon_a = exp_ack.pop_front();
          check("ack_mask", req_ack, mon_a);
        end
        // RELEASE is the third cycle counting the push cycle itself
        check("ack_latency", cyc - last_push_cyc, 2);
      end
      prev_ack = req_ack;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push_only(input logic [7:0] d, input logic [1:0] id);
    push_t e;
    e.data = d;
    e.id   = id;
    exp_push.push_back(e);
  endtask

  task automatic expect_xfer(input logic [7:0] d, input logic [1:0] id);
    expect_push_only(d, id);
    exp_ack.push_back(4'b0001 << id);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    err_clr   = 1'b0;
    pop_req   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_fifo_push", fifo_push, 0);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
  endtask

  // Requester behaviour: wait (bounded) for its req_ack, then in the next
  // cycle either drop req_valid or present a new word.
  task automatic serve(input int idx, input logic nv, input logic [7:0] nd, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (req_ack[idx] !== 1'b1 && waited < 40);
    check("serve_ack_seen", req_ack[idx], 1);
    step();
    req_valid[idx]          = nv;
    req_data[idx*DW +: DW]  = nd;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_push.size() != 0 || exp_ack.size() != 0) && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", exp_push.size() + exp_ack.size(), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 40);
    check("reached_idle", busy, 0);
  endtask

  task automatic pop_word(output logic [7:0] d);
    step();
    pop_req = 1'b1;
    d       = data_out;
    step();
    pop_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         w;
    logic [7:0] d;
    logic [7:0] rr_exp [5];

    tests = 0;  fails = 0;  cyc = 0;  last_push_cyc = 0;  prev_ack = '0;
    reset = 1'b1;  req_valid = '0;  req_data = '0;  err_clr = 1'b0;
    pop_req = 1'b0;  ack_en = 1'b1;  fifo_depth = 16;

    // ---- Single requester -------------------------------------------------
    do_reset();
    step();
    req_valid[2]    = 1'b1;
    req_data[23:16] = 8'hA5;
    expect_xfer(8'hA5, 2'd2);
    serve(2, 1'b0, 8'h00, w);
    wait_drain();
    check("single_grant_id_held", grant_id, 2);
    pop_word(d);
    check("single_fifo_out", d, 8'hA5);

    // ---- Round-robin fairness ---------------------------------------------
    do_reset();
    push_cyc.delete();
    step();
    req_valid = 4'b1111;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    expect_xfer(8'h10, 2'd0);
    expect_xfer(8'h11, 2'd1);
    expect_xfer(8'h12, 2'd2);
    expect_xfer(8'h13, 2'd3);
    expect_xfer(8'h14, 2'd0);
    serve(0, 1'b1, 8'h14, w);
    serve(1, 1'b0, 8'h00, w);
    serve(2, 1'b0, 8'h00, w);
    serve(3, 1'b0, 8'h00, w);
    serve(0, 1'b0, 8'h00, w);
    wait_drain();
    check("rr_push_count", push_cyc.size(), 5);
    for (int i = 1; i < push_cyc.size(); i++) begin
      check("rr_push_period", push_cyc[i] - push_cyc[i-1], 4);
    end
    rr_exp[0] = 8'h10;  rr_exp[1] = 8'h11;  rr_exp[2] = 8'h12;
    rr_exp[3] = 8'h13;  rr_exp[4] = 8'h14;
    for (int i = 0; i < 5; i++) begin
      pop_word(d);
      check("rr_pop_order", d, rr_exp[i]);
    end
    // Last grant was 0, so rr_ptr=1; serving requester 1 moves it to 2.
    step();
    req_valid[1]    = 1'b1;
    req_data[15:8]  = 8'h21;
    expect_xfer(8'h21, 2'd1);
    serve(1, 1'b0, 8'h00, w);
    // With rr_ptr=2, requester 3 must win over requester 1.
    step();
    req_valid       = 4'b1010;
    req_data[15:8]  = 8'h31;
    req_data[31:24] = 8'h33;
    expect_xfer(8'h33, 2'd3);
    expect_xfer(8'h31, 2'd1);
    serve(3, 1'b0, 8'h00, w);
    serve(1, 1'b0, 8'h00, w);
    wait_drain();

    // ---- Full stall (depth 2) ---------------------------------------------
    do_reset();
    fifo_depth = 2;
    step();
    req_valid[0]   = 1'b1;
    req_data[7:0]  = 8'h40;
    expect_xfer(8'h40, 2'd0);
    expect_xfer(8'h41, 2'd0);
    expect_xfer(8'h42, 2'd0);
    serve(0, 1'b1, 8'h41, w);
    serve(0, 1'b1, 8'h42, w);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_busy", busy, 0);
      check("stall_no_push", fifo_push, 0);
    end
    pop_word(d);
    check("stall_pop0", d, 8'h40);
    serve(0, 1'b0, 8'h00, w);
    check("stall_ack_within_4", w <= 4, 1);
    wait_drain();
    pop_word(d);
    check("stall_pop1", d, 8'h41);
    pop_word(d);
    check("stall_pop2", d, 8'h42);
    fifo_depth = 16;

    // ---- Requester withdraws after grant ----------------------------------
    do_reset();
    step();
    req_valid[1]   = 1'b1;
    req_data[15:8] = 8'h55;
    expect_xfer(8'h55, 2'd1);
    step();
    check("withdraw_granted", busy, 1);
    req_valid[1] = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);
    check("withdraw_idle", busy, 0);
    pop_word(d);
    check("withdraw_pop", d, 8'h55);

    // ---- Ack timeout, retry, err_clr --------------------------------------
    do_reset();
    ack_en = 1'b0;
    expect_push_only(8'h66, 2'd0);
    expect_push_only(8'h66, 2'd0);
    step();
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h66;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 8) begin
        @(negedge clk);
        check("timeout_err_before", err, 0);
      end
      if (k == 9) begin
        @(negedge clk);
        check("timeout_err_set", err, 1);
        check("timeout_back_idle", busy, 0);
      end
    end
    step();                  // retry is in PUSH now
    req_valid[0] = 1'b0;
    wait_idle();
    check("timeout_err_sticky", err, 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_clr_clears", err, 0);
    // err_clr coincident with a new timeout: set wins
    expect_push_only(8'h77, 2'd0);
    step();
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h77;
    step();
    req_valid[0] = 1'b0;
    repeat (6) step();
    step();
    err_clr = 1'b1;
    @(negedge clk);
    check("coinc_err_before", err, 0);
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check("coinc_set_wins", err, 1);
    wait_drain();
    ack_en = 1'b1;

    // ---- Async reset in ACK_WAIT (err still set from above) ---------------
    step();
    req_valid[2]    = 1'b1;
    req_data[23:16] = 8'hC2;
    expect_xfer(8'hC2, 2'd2);
    serve(2, 1'b0, 8'h00, w);        // rr_ptr now 3
    ack_en = 1'b0;
    step();
    req_valid[1]    = 1'b1;
    req_valid[3]    = 1'b1;
    req_data[15:8]  = 8'h81;
    req_data[31:24] = 8'h83;
    expect_push_only(8'h83, 2'd3);   // abandoned by the reset below
    step();
    step();                          // ACK_WAIT
    check("areset_in_ack_wait", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_busy", busy, 0);
    check("areset_req_ack", req_ack, 0);
    check("areset_fifo_push", fifo_push, 0);
    check("areset_fifo_data", fifo_data, 0);
    check("areset_grant_id", grant_id, 0);
    check("areset_err", err, 0);
    ack_en = 1'b1;
    // rr_ptr restarts at 0, so requester 1 is regranted before 3
    expect_xfer(8'h81, 2'd1);
    expect_xfer(8'h83, 2'd3);
    step();
    reset = 1'b0;
    serve(1, 1'b0, 8'h00, w);
    serve(3, 1'b0, 8'h00, w);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
